// File: rtl/reflet_vga_rect_fill.sv
// Rectangle fill engine: one command per valid/ready handshake, one clipped pixel write per clock in raster order.
// Optional outline-only mode is enabled by defining REFLET_VGA_RECT_FILL_OUTLINE_EN (adds the cmd_outline input).
module reflet_vga_rect_fill #(
  parameter int h_size        = 640,
  parameter int v_line        = 480,
  parameter int color_depth   = 8,
  parameter int bit_reduction = 0,
  localparam int HW = $clog2(h_size) - bit_reduction,
  localparam int VW = $clog2(v_line) - bit_reduction
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [HW-1:0]          cmd_h_start,
  input  logic [VW-1:0]          cmd_v_start,
  input  logic [HW:0]            cmd_width,
  input  logic [VW:0]            cmd_height,
  input  logic [color_depth-1:0] cmd_R,
  input  logic [color_depth-1:0] cmd_G,
  input  logic [color_depth-1:0] cmd_B,
  input  logic [color_depth-1:0] cmd_a,
`ifdef REFLET_VGA_RECT_FILL_OUTLINE_EN
  input  logic                   cmd_outline,
`endif
  output logic                   write_en,
  output logic [HW-1:0]          h_pixel_write,
  output logic [VW-1:0]          v_pixel_write,
  output logic [color_depth-1:0] R_write,
  output logic [color_depth-1:0] G_write,
  output logic [color_depth-1:0] B_write,
  output logic [color_depth-1:0] a_write,
  output logic                   busy,
  output logic                   done
);

  localparam logic [HW:0] HMAX = (HW+1)'(h_size >> bit_reduction);
  localparam logic [VW:0] VMAX = (VW+1)'(v_line >> bit_reduction);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        state, state_next;
  logic [HW:0]   h_room, ew;
  logic [VW:0]   v_room, eh;
  logic [HW-1:0] h_last_c, h_start_q, h_last, h_next;
  logic [VW-1:0] v_last_c, v_last, v_next;
  logic          cmd_zero, h_wrap, last_px, we_next;
`ifdef REFLET_VGA_RECT_FILL_OUTLINE_EN
  logic [VW-1:0] v_start_q;
  logic          outline_q;
`endif

  // Clipped extents are computed one bit wider than the coordinates so HMAX-h_start cannot wrap.
  always_comb begin
    h_room = HMAX - {1'b0, cmd_h_start};
    v_room = VMAX - {1'b0, cmd_v_start};
    ew     = '0;
    eh     = '0;
    if ({1'b0, cmd_h_start} < HMAX) ew = (cmd_width < h_room) ? cmd_width : h_room;
    if ({1'b0, cmd_v_start} < VMAX) eh = (cmd_height < v_room) ? cmd_height : v_room;
    h_last_c = cmd_h_start + ew[HW-1:0] - HW'(1);
    v_last_c = cmd_v_start + eh[VW-1:0] - VW'(1);
    cmd_zero = (ew == '0) || (eh == '0);
  end

  // Raster stepping from the current write position.
  always_comb begin
    h_wrap  = (h_pixel_write == h_last);
    last_px = h_wrap && (v_pixel_write == v_last);
    h_next  = h_wrap ? h_start_q : h_pixel_write + HW'(1);
    v_next  = h_wrap ? v_pixel_write + VW'(1) : v_pixel_write;
`ifdef REFLET_VGA_RECT_FILL_OUTLINE_EN
    we_next = !outline_q || (h_next == h_start_q) || (h_next == h_last) ||
              (v_next == v_start_q) || (v_next == v_last);
`else
    we_next = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first, so no path through this block leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_next = cmd_zero ? DONE : FILL;
      FILL:    if (last_px)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Write port: coordinates and colour hold their last values whenever write_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en      <= 1'b0;
      done          <= 1'b0;
      h_pixel_write <= '0;
      v_pixel_write <= '0;
      R_write       <= '0;
      G_write       <= '0;
      B_write       <= '0;
      a_write       <= '0;
      h_start_q     <= '0;
      h_last        <= '0;
      v_last        <= '0;
`ifdef REFLET_VGA_RECT_FILL_OUTLINE_EN
      v_start_q     <= '0;
      outline_q     <= 1'b0;
`endif
    end else begin
      write_en <= 1'b0;
      done     <= (state_next == DONE);
      unique case (state)
        IDLE: if (cmd_valid && !cmd_zero) begin
          h_pixel_write <= cmd_h_start;
          v_pixel_write <= cmd_v_start;
          R_write       <= cmd_R;
          G_write       <= cmd_G;
          B_write       <= cmd_B;
          a_write       <= cmd_a;
          h_start_q     <= cmd_h_start;
          h_last        <= h_last_c;
          v_last        <= v_last_c;
          write_en      <= 1'b1;  // first pixel is always a corner, so written in either mode
`ifdef REFLET_VGA_RECT_FILL_OUTLINE_EN
          v_start_q     <= cmd_v_start;
          outline_q     <= cmd_outline;
`endif
        end
        FILL: if (!last_px) begin
          h_pixel_write <= h_next;
          v_pixel_write <= v_next;
          write_en      <= we_next;
        end
        default: ;
      endcase
    end
  end

endmodule
